// File: rtl/wb_stage_regfile_if.sv
// Bundle between the DM/WB pipeline register and decode on one side and the writeback stage on the other.
// The master side drives the WB-stage fields and the read addresses; the slave is wb_stage_regfile.
interface wb_stage_regfile_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       inst_WB;
    logic [31:0]       pc_WB;
    logic              is_Ld_WB;
    logic [DATA_W-1:0] aluResult_WB;
    logic [DATA_W-1:0] DMResult_WB;
    logic [4:0]        rd_WB;
    logic              isWb_WB;
    logic              isCall_WB;
    logic              stall_WB;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] wbData_WB;
    logic [4:0]        wbRd_WB;
    logic              wbValid_WB;
    logic [31:0]       retire_count;

    modport master (
        output inst_WB, pc_WB, is_Ld_WB, aluResult_WB, DMResult_WB, rd_WB,
               isWb_WB, isCall_WB, stall_WB, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wbData_WB, wbRd_WB, wbValid_WB, retire_count
    );

    modport slave (
        input  inst_WB, pc_WB, is_Ld_WB, aluResult_WB, DMResult_WB, rd_WB,
               isWb_WB, isCall_WB, stall_WB, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wbData_WB, wbRd_WB, wbValid_WB, retire_count
    );
endinterface

// File: rtl/wb_stage_regfile.sv
// SimpleRISC writeback stage: selects the writeback value, commits it to the register file, counts retirements.
// Optional macro WB_BYPASS_EN makes the read ports write-through for a commit happening this cycle.
module wb_stage_regfile #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    parameter int RA_IDX   = 15,
    parameter int PC_INC   = 4
) (
    input logic              clk,
    input logic              rst_n,
    wb_stage_regfile_if.slave wb
);
    localparam int           IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0]   NUM_REGS_L = 6'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [31:0]       retire_q;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_rd;
    logic              wb_valid;
    logic              unused_inst;

    // The instruction word travels with the stage only for waveform debug.
    assign unused_inst = ^wb.inst_WB;

    // Call outranks load, load outranks ALU.
    always_comb begin
        wb_data = wb.aluResult_WB;
        wb_rd   = wb.rd_WB;
        if (wb.isCall_WB) begin
            wb_data = DATA_W'(wb.pc_WB + 32'(PC_INC));
            wb_rd   = 5'(RA_IDX);
        end else if (wb.is_Ld_WB) begin
            wb_data = wb.DMResult_WB;
        end
    end

    assign wb_valid = (wb.isWb_WB | wb.isCall_WB) & ~wb.stall_WB
                      & ({1'b0, wb_rd} < NUM_REGS_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            retire_q <= '0;
        end else if (wb_valid) begin
            regs[wb_rd[IDX_W-1:0]] <= wb_data;
            retire_q               <= retire_q + 32'd1;
        end
    end

    function automatic logic [DATA_W-1:0] read_array(input logic [4:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if ({1'b0, addr} < NUM_REGS_L) begin
            val = regs[addr[IDX_W-1:0]];
        end
        return val;
    endfunction

`ifdef WB_BYPASS_EN
    // Forward the value being committed so decode needs no hazard stall.
    assign wb.rs1_data = (wb_valid && (wb.rs1_addr == wb_rd)) ? wb_data : read_array(wb.rs1_addr);
    assign wb.rs2_data = (wb_valid && (wb.rs2_addr == wb_rd)) ? wb_data : read_array(wb.rs2_addr);
`else
    assign wb.rs1_data = read_array(wb.rs1_addr);
    assign wb.rs2_data = read_array(wb.rs2_addr);
`endif

    assign wb.wbData_WB    = wb_data;
    assign wb.wbRd_WB      = wb_rd;
    assign wb.wbValid_WB   = wb_valid;
    assign wb.retire_count = retire_q;
endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed testbench for wb_stage_regfile; handles both WB_BYPASS_EN builds.
module tb_wb_stage_regfile;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] exp_cnt;

    wb_stage_regfile_if #(.DATA_W(32)) bus ();

    wb_stage_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.inst_WB      = 32'h0000_0013;
        bus.pc_WB        = '0;
        bus.is_Ld_WB     = 1'b0;
        bus.aluResult_WB = '0;
        bus.DMResult_WB  = '0;
        bus.rd_WB        = '0;
        bus.isWb_WB      = 1'b0;
        bus.isCall_WB    = 1'b0;
        bus.stall_WB     = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] val);
        idle();
        bus.isWb_WB      = 1'b1;
        bus.rd_WB        = rd;
        bus.aluResult_WB = val;
    endtask

    task automatic test_reset();
        idle();
        drive_alu(5'd3, 32'h0000_0011);
        tick();
        idle();
        // Pending write to r3 while reset asserts: reset must win.
        drive_alu(5'd3, 32'h0000_0033);
        rst_n = 1'b0;
        tick();
        idle();
        bus.rs1_addr = 5'd3;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0) begin
            failures++; $display("FAIL reset_r3 got=%h exp=%h", bus.rs1_data, 32'h0);
        end
        checks++;
        if (bus.retire_count !== 32'h0) begin
            failures++; $display("FAIL reset_count got=%h exp=%h", bus.retire_count, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 32'h0;
        for (int i = 0; i < 16; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(15 - i);
            #1;
            checks++;
            if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
                failures++;
                $display("FAIL reset_clear r%0d got=%h/%h exp=0", i, bus.rs1_data, bus.rs2_data);
            end
        end
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        drive_alu(5'd5, 32'h1234_5678);
        #1;
        checks++;
        if (bus.wbValid_WB !== 1'b1 || bus.wbRd_WB !== 5'd5 || bus.wbData_WB !== 32'h1234_5678) begin
            failures++;
            $display("FAIL alu_comb got=%b/%0d/%h exp=1/5/12345678", bus.wbValid_WB, bus.wbRd_WB, bus.wbData_WB);
        end
        tick();
        idle();
        exp_cnt++;
        bus.rs1_addr = 5'd5;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h1234_5678) begin
            failures++; $display("FAIL alu_r5 got=%h exp=%h", bus.rs1_data, 32'h1234_5678);
        end
        checks++;
        if (bus.retire_count !== exp_cnt) begin
            failures++; $display("FAIL alu_count got=%h exp=%h", bus.retire_count, exp_cnt);
        end
    endtask

    task automatic test_load_call();
        @(negedge clk);
        idle();
        bus.is_Ld_WB     = 1'b1;
        bus.isWb_WB      = 1'b1;
        bus.rd_WB        = 5'd2;
        bus.DMResult_WB  = 32'hDEAD_BEEF;
        bus.aluResult_WB = 32'h0000_0BAD;
        tick();
        exp_cnt++;
        idle();
        bus.isCall_WB    = 1'b1;
        bus.is_Ld_WB     = 1'b1;
        bus.pc_WB        = 32'h0000_0100;
        bus.rd_WB        = 5'd7;
        bus.DMResult_WB  = 32'h7777_7777;
        bus.aluResult_WB = 32'h6666_6666;
        #1;
        checks++;
        if (bus.wbRd_WB !== 5'd15 || bus.wbData_WB !== 32'h0000_0104 || bus.wbValid_WB !== 1'b1) begin
            failures++;
            $display("FAIL call_comb got=%0d/%h/%b exp=15/00000104/1", bus.wbRd_WB, bus.wbData_WB, bus.wbValid_WB);
        end
        tick();
        exp_cnt++;
        idle();
        bus.rs1_addr = 5'd2;
        bus.rs2_addr = 5'd15;
        #1;
        checks++;
        if (bus.rs1_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL load_r2 got=%h exp=%h", bus.rs1_data, 32'hDEAD_BEEF);
        end
        checks++;
        if (bus.rs2_data !== 32'h0000_0104) begin
            failures++; $display("FAIL call_r15 got=%h exp=%h", bus.rs2_data, 32'h0000_0104);
        end
        bus.rs1_addr = 5'd7;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0) begin
            failures++; $display("FAIL call_r7 got=%h exp=%h", bus.rs1_data, 32'h0);
        end
        checks++;
        if (bus.retire_count !== exp_cnt) begin
            failures++; $display("FAIL load_call_count got=%h exp=%h", bus.retire_count, exp_cnt);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        drive_alu(5'd4, 32'hA5A5_A5A5);
        bus.stall_WB = 1'b1;
        bus.rs1_addr = 5'd4;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.wbValid_WB !== 1'b0) begin
                failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=0", c, bus.wbValid_WB);
            end
            tick();
            checks++;
            if (bus.rs1_data !== 32'h0 || bus.retire_count !== exp_cnt) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%h/%h exp=0/%h", c, bus.rs1_data, bus.retire_count, exp_cnt);
            end
        end
        bus.stall_WB = 1'b0;
        tick();
        exp_cnt++;
        idle();
        #1;
        checks++;
        if (bus.rs1_data !== 32'hA5A5_A5A5) begin
            failures++; $display("FAIL stall_release_r4 got=%h exp=%h", bus.rs1_data, 32'hA5A5_A5A5);
        end
        tick();
        checks++;
        if (bus.retire_count !== exp_cnt) begin
            failures++; $display("FAIL stall_count_once got=%h exp=%h", bus.retire_count, exp_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        @(negedge clk);
        drive_alu(5'd6, 32'h1111_1111);
        tick();
        exp_cnt++;
        drive_alu(5'd6, 32'hCAFE_F00D);
        bus.rs2_addr = 5'd6;
        bus.rs1_addr = 5'd5;
`ifdef WB_BYPASS_EN
        exp_same = 32'hCAFE_F00D;
`else
        exp_same = 32'h1111_1111;
`endif
        #1;
        checks++;
        if (bus.rs2_data !== exp_same) begin
            failures++; $display("FAIL bypass_same_cycle got=%h exp=%h", bus.rs2_data, exp_same);
        end
        checks++;
        if (bus.rs1_data !== 32'h1234_5678) begin
            failures++; $display("FAIL bypass_other_port got=%h exp=%h", bus.rs1_data, 32'h1234_5678);
        end
        tick();
        exp_cnt++;
        idle();
        #1;
        checks++;
        if (bus.rs2_data !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL bypass_next_cycle got=%h exp=%h", bus.rs2_data, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_boundaries();
        @(negedge clk);
        drive_alu(5'd16, 32'h9999_9999);
        #1;
        checks++;
        if (bus.wbValid_WB !== 1'b0) begin
            failures++; $display("FAIL rd16_valid got=%b exp=0", bus.wbValid_WB);
        end
        tick();
        idle();
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd20;
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0 || bus.retire_count !== exp_cnt) begin
            failures++; $display("FAIL rd16_nowrite got=%h/%h exp=0/%h", bus.rs1_data, bus.retire_count, exp_cnt);
        end
        checks++;
        if (bus.rs2_data !== 32'h0) begin
            failures++; $display("FAIL read_idx20 got=%h exp=0", bus.rs2_data);
        end
        drive_alu(5'd0, 32'h0000_005A);
        tick();
        exp_cnt++;
        idle();
        bus.isCall_WB = 1'b1;
        bus.pc_WB     = 32'hFFFF_FFFC;
        bus.rs2_addr  = 5'd15;
        tick();
        exp_cnt++;
        idle();
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0000_005A) begin
            failures++; $display("FAIL r0_writable got=%h exp=%h", bus.rs1_data, 32'h0000_005A);
        end
        checks++;
        if (bus.rs2_data !== 32'h0) begin
            failures++; $display("FAIL call_pc_wrap got=%h exp=0", bus.rs2_data);
        end
        checks++;
        if (bus.retire_count !== exp_cnt) begin
            failures++; $display("FAIL boundary_count got=%h exp=%h", bus.retire_count, exp_cnt);
        end
    endtask

    task automatic test_count_wrap();
        @(negedge clk);
        idle();
        force dut.retire_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_q;
        drive_alu(5'd9, 32'h0000_0009);
        tick();
        idle();
        #1;
        checks++;
        if (bus.retire_count !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL count_max got=%h exp=%h", bus.retire_count, 32'hFFFF_FFFF);
        end
        drive_alu(5'd10, 32'h0000_000A);
        tick();
        idle();
        #1;
        checks++;
        if (bus.retire_count !== 32'h0) begin
            failures++; $display("FAIL count_wrap got=%h exp=0", bus.retire_count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = '0;
        rst_n    = 1'b0;
        idle();
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_alu_write();
        test_load_call();
        test_stall();
        test_bypass();
        test_boundaries();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
